// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and
// saturating stall counter. Each operand channel and the control bundle use one lane instance.

module pipe_stage_skid_lane #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_main_i,   // upstream word -> main
  input  logic         ld_s2m_i,    // skid word -> main
  input  logic         ld_skid_i,   // upstream word -> skid
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] m_q, s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (ld_s2m_i)       m_q <= s_q;
      else if (ld_main_i) m_q <= d_i;
      if (ld_skid_i)      s_q <= d_i;
    end
  end

  assign q_o = m_q;
endmodule

module pipe_stage_skid_reg #(
  parameter int               CTRL_W    = 11,
  parameter int               DATA_W    = 32,
  parameter int               NUM_CH    = 3,
  parameter logic [CTRL_W-1:0] KILL_MASK = 11'b110_0000_0010,
  parameter int               CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     cnt_clear,
  output logic [CNT_W-1:0]         stall_cnt
);
  logic m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic ld_main, ld_s2m, ld_skid, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTRL_W-1:0] m_ctrl;
  logic [NUM_CH-1:0][DATA_W-1:0] m_data;

  assign accept = in_valid & ~s_valid_q;

  // Skid only fills while main is held, so "main free" with skid full always drains skid first.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    ld_main   = 1'b0;
    ld_s2m    = 1'b0;
    ld_skid   = 1'b0;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_ready) begin
      if (s_valid_q) begin
        ld_s2m    = 1'b1;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        ld_main   = 1'b1;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      ld_skid   = 1'b1;
      s_valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear)
      cnt_d = '0;
    else if (m_valid_q && !out_ready && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  pipe_stage_skid_lane #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .reset(reset), .ld_main_i(ld_main), .ld_s2m_i(ld_s2m), .ld_skid_i(ld_skid),
    .d_i(in_ctrl), .q_o(m_ctrl)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pipe_stage_skid_lane #(.W(DATA_W)) u_lane (
      .clk(clk), .reset(reset), .ld_main_i(ld_main), .ld_s2m_i(ld_s2m), .ld_skid_i(ld_skid),
      .d_i(in_data[ch*DATA_W +: DATA_W]), .q_o(m_data[ch])
    );
  end

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  // Stale ctrl after a drain or flush must not be able to write state downstream.
  assign out_ctrl  = m_ctrl & ~(KILL_MASK & {CTRL_W{~m_valid_q}});
  assign out_data  = m_data;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: three instances (default, 1x8b with 4b counter, 4x64b)
// share one stimulus stream and are checked against a queue-based reference model.

module tb_pipe_stage_skid_reg;
  localparam logic [10:0] KM = 11'b110_0000_0010;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready, cnt_clear;
  logic [10:0]  in_ctrl;
  logic [255:0] din;

  logic d0_ir, d0_ov, d1_ir, d1_ov, d2_ir, d2_ov;
  logic [10:0] d0_oc, d1_oc, d2_oc;
  logic [95:0] d0_od;
  logic [7:0]  d1_od;
  logic [255:0] d2_od;
  logic [15:0] d0_sc, d2_sc;
  logic [3:0]  d1_sc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d0_ir), .in_ctrl(in_ctrl),
    .in_data(din[95:0]), .flush(flush), .out_valid(d0_ov), .out_ready(out_ready),
    .out_ctrl(d0_oc), .out_data(d0_od), .cnt_clear(cnt_clear), .stall_cnt(d0_sc)
  );

  pipe_stage_skid_reg #(.DATA_W(8), .NUM_CH(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d1_ir), .in_ctrl(in_ctrl),
    .in_data(din[7:0]), .flush(flush), .out_valid(d1_ov), .out_ready(out_ready),
    .out_ctrl(d1_oc), .out_data(d1_od), .cnt_clear(cnt_clear), .stall_cnt(d1_sc)
  );

  pipe_stage_skid_reg #(.DATA_W(64), .NUM_CH(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d2_ir), .in_ctrl(in_ctrl),
    .in_data(din), .flush(flush), .out_valid(d2_ov), .out_ready(out_ready),
    .out_ctrl(d2_oc), .out_data(d2_od), .cnt_clear(cnt_clear), .stall_cnt(d2_sc)
  );

  // Reference model: the stage is a FIFO of depth 2; upstream may push only when it holds < 2.
  logic [10:0]  qc[$];
  logic [255:0] qd[$];
  logic [10:0]  lc;
  logic [255:0] ld;
  int  stalls = 0;
  bit  mrdy;

  always @(posedge clk) begin
    if (reset) begin
      qc.delete(); qd.delete();
      lc = '0; ld = '0; stalls = 0;
    end else begin
      mrdy = qc.size() < 2;
      if (cnt_clear) stalls = 0;
      else if (qc.size() > 0 && !out_ready) stalls++;
      if (flush) begin
        qc.delete(); qd.delete();
      end else begin
        if (qc.size() > 0 && out_ready) begin
          void'(qc.pop_front()); void'(qd.pop_front());
        end
        if (in_valid && mrdy) begin
          qc.push_back(in_ctrl); qd.push_back(din);
        end
      end
      if (qc.size() > 0) begin lc = qc[0]; ld = qd[0]; end
    end
  end

  logic e_ov, e_ir;
  logic [10:0]  e_oc;
  logic [255:0] e_od;
  logic [15:0]  e_sc16;
  logic [3:0]   e_sc4;

  task automatic expect_now();
    e_ov   = qc.size() > 0;
    e_ir   = qc.size() < 2;
    e_oc   = e_ov ? qc[0] : (lc & ~KM);
    e_od   = e_ov ? qd[0] : ld;
    e_sc16 = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
    e_sc4  = (stalls > 15) ? 4'hF : 4'(stalls);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    expect_now();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_ctrl = 11'h7FF; din = {8{32'hA5A5_5A5A}};
    flush = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    repeat (2) tick();
    reset = 1'b0; in_valid = 1'b0;
    n_tests++; if (d0_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", d0_ov); end
    n_tests++; if (d0_oc !== 11'h0) begin n_fail++; $display("FAIL reset_out_ctrl got %h want 000", d0_oc); end
    n_tests++; if (d0_sc !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", d0_sc); end
    n_tests++; if (d0_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", d0_ir); end
    n_tests++; if (d2_od !== 256'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", d2_od); end
    tick();
    n_tests++; if (d0_ov !== 1'b0 || d1_ov !== 1'b0) begin n_fail++; $display("FAIL reset_idle got %0b%0b want 00", d0_ov, d1_ov); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_ctrl  = 11'(k);
      din      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      din[63:0] = 64'h1000 + 64'(k);
      tick();
      n_tests++;
      if (d0_ov !== 1'b1 || d0_oc !== 11'(k) || d0_od[31:0] !== (32'h1000 + 32'(k)) || d0_ir !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d got v=%0b c=%h d=%h r=%0b want v=1 c=%h d=%h r=1",
                           k, d0_ov, d0_oc, d0_od[31:0], d0_ir, 11'(k), 32'h1000 + 32'(k));
      end
      n_tests++;
      if (d1_od !== 8'(k) || d2_od[63:0] !== (64'h1000 + 64'(k)) || d0_od !== e_od[95:0] || d2_od !== e_od) begin
        n_fail++; $display("FAIL stream_slice_%0d got d1=%h d2ch0=%h want d1=%h d2ch0=%h",
                           k, d1_od, d2_od[63:0], 8'(k), 64'h1000 + 64'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++; if (d0_ov !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %0b want 0", d0_ov); end
  endtask

  task automatic test_back_pressure();
    logic [10:0]  bc[3];
    logic [255:0] bd[3];
    logic [10:0]  got[$];
    int idx = 0;
    bit rdy;
    bc[0] = 11'h4A1; bc[1] = 11'h2B2; bc[2] = 11'h6C3;
    for (int i = 0; i < 3; i++) bd[i] = {8{$urandom}};
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    for (int c = 0; c < 14 && got.size() < 3; c++) begin
      out_ready = (c >= 4);
      in_valid  = (idx < 3);
      in_ctrl   = bc[idx % 3];
      din       = bd[idx % 3];
      rdy = d0_ir;
      if (d0_ov && out_ready) got.push_back(d0_oc);
      tick();
      if (in_valid && rdy) idx++;
      if (c == 3) begin
        n_tests++;
        if (d0_oc !== bc[0] || d0_ir !== 1'b0 || d0_sc !== 16'd3) begin
          n_fail++; $display("FAIL bp_hold got c=%h r=%0b s=%0d want c=%h r=0 s=3", d0_oc, d0_ir, d0_sc, bc[0]);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL bp_count got %0d want 3", got.size());
    end else if (got[0] !== bc[0] || got[1] !== bc[1] || got[2] !== bc[2]) begin
      n_fail++; $display("FAIL bp_order got %h %h %h want %h %h %h", got[0], got[1], got[2], bc[0], bc[1], bc[2]);
    end
    n_tests++; if (d0_sc !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt got %0d want 3", d0_sc); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 11'h7F1; din = {8{32'h1111_AAAA}}; tick();
    in_ctrl = 11'h602; din = {8{32'h2222_BBBB}}; tick();
    n_tests++; if (d0_ir !== 1'b0 || d0_oc !== 11'h7F1) begin n_fail++; $display("FAIL flush_setup got r=%0b c=%h want r=0 c=7f1", d0_ir, d0_oc); end
    flush = 1'b1; in_ctrl = 11'h7FF; din = {8{32'h3333_CCCC}}; tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (d0_ov !== 1'b0 || (d0_oc & KM) !== 11'h0 || d0_ir !== 1'b1 || d0_oc !== (11'h7F1 & ~KM)) begin
      n_fail++; $display("FAIL flush_kill got v=%0b c=%h r=%0b want v=0 c=%h r=1", d0_ov, d0_oc, d0_ir, 11'h7F1 & ~KM);
    end
    out_ready = 1'b1; tick();
    n_tests++; if (d0_ov !== 1'b0 || d2_ov !== 1'b0) begin n_fail++; $display("FAIL flush_lost got %0b want 0", d0_ov); end
  endtask

  task automatic test_counter();
    cnt_clear = 1'b1; out_ready = 1'b0; tick(); cnt_clear = 1'b0;
    in_valid = 1'b1; in_ctrl = 11'h155; din = {8{$urandom}}; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    n_tests++; if (d1_sc !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate got %0d want 15", d1_sc); end
    n_tests++; if (d0_sc !== 16'd20 || d0_sc !== e_sc16) begin n_fail++; $display("FAIL cnt_wide got %0d want 20", d0_sc); end
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    n_tests++; if (d1_sc !== 4'h0 || d0_sc !== 16'h0) begin n_fail++; $display("FAIL cnt_clear got %0d/%0d want 0", d1_sc, d0_sc); end
    tick();
    n_tests++; if (d1_sc !== 4'h1 || d2_sc !== 16'h1) begin n_fail++; $display("FAIL cnt_restart got %0d want 1", d1_sc); end
    out_ready = 1'b1; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      cnt_clear = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_ctrl   = 11'($urandom);
      din       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      n_tests++;
      if ({d0_ov, d0_ir, d0_oc} !== {e_ov, e_ir, e_oc} || {d1_ov, d1_ir, d1_oc} !== {e_ov, e_ir, e_oc} ||
          {d2_ov, d2_ir, d2_oc} !== {e_ov, e_ir, e_oc}) begin
        n_fail++; $display("FAIL rand_hs_%0d got v=%0b r=%0b c=%h want v=%0b r=%0b c=%h", c, d0_ov, d0_ir, d0_oc, e_ov, e_ir, e_oc);
      end
      n_tests++;
      if (d0_od !== e_od[95:0] || d1_od !== e_od[7:0] || d2_od !== e_od) begin
        n_fail++; $display("FAIL rand_data_%0d got %h want %h", c, d2_od, e_od);
      end
      n_tests++;
      if (d0_sc !== e_sc16 || d1_sc !== e_sc4 || d2_sc !== e_sc16) begin
        n_fail++; $display("FAIL rand_cnt_%0d got %0d/%0d want %0d/%0d", c, d0_sc, d1_sc, e_sc16, e_sc4);
      end
    end
    reset = 1'b0; flush = 1'b0; cnt_clear = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_counter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
